// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with sign handling on magnitudes and a one-cycle register-file write strobe on completion.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            writereg_out
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t            state, state_nx;
    logic [2:0]        op;
    logic [XLEN-1:0]   ra, rb;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic              sa, sb;

    // Operand classification at the accept edge
    logic            in_sa, in_sb, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        in_sa       = ((funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]))
                      && op_a[XLEN-1];
        in_sb       = ((funct3 == 3'b001) || (funct3[2] && !funct3[0])) && op_b[XLEN-1];
        div_zero    = funct3[2] && (op_b == '0);
        div_ovf     = funct3[2] && !funct3[0] && (op_a == SMIN) && (op_b == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? op_a : '1;
        else if (div_ovf)
            special_res = funct3[1] ? '0 : SMIN;
    end

    // Iteration datapath: ra = multiplicand / shifting dividend, rb = shifting multiplier / divisor.
    // For divide, acc holds {remainder, quotient}.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_step;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (rb[0] ? {1'b0, ra} : '0);
        shifted  = {acc[2*XLEN-1:XLEN], ra[XLEN-1]};
        diff     = {1'b0, shifted} - {2'b00, rb};
        q_bit    = !diff[XLEN+1];
        rem_step = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

    // Sign correction and output select
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = (sa ^ sb) ? -acc : acc;
        quo_fix  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = special ? DONE : RUN;
            RUN:     if (cnt == CW'(XLEN-1)) state_nx = FIX;
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op     <= '0;
            ra     <= '0;
            rb     <= '0;
            acc    <= '0;
            cnt    <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    op     <= funct3;
                    rd_out <= rd_in;
                    sa     <= in_sa;
                    sb     <= in_sb;
                    ra     <= in_sa ? -op_a : op_a;
                    rb     <= in_sb ? -op_b : op_b;
                    acc    <= '0;
                    cnt    <= '0;
                    if (special) result <= special_res;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op[2]) begin
                        acc <= {rem_step, acc[XLEN-2:0], q_bit};
                        ra  <= ra << 1;
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                        rb  <= rb >> 1;
                    end
                end
                FIX:     result <= fix_res;
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign writereg_out = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV32M cases plus randomized ops against an
// arithmetic reference model.
module tb_mdu_iter;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done, writereg_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_assert = 0;
    int n_fail   = 0;

    mdu_iter #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out), .writereg_out(writereg_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the RV32M definitions using wide arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] as_, bs_, p_s;
        logic [63:0]        au, bu, p_u;
        logic signed [31:0] sa_, sb_;
        logic               ovf;
        as_ = {{32{a[31]}}, a};
        bs_ = {{32{b[31]}}, b};
        au  = {32'd0, a};
        bu  = {32'd0, b};
        sa_ = a;
        sb_ = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p_u = au * bu;   return p_u[31:0];  end
            3'b001: begin p_s = as_ * bs_; return p_s[63:32]; end
            3'b010: begin p_s = as_ * $signed(bu); return p_s[63:32]; end
            3'b011: begin p_u = au * bu;   return p_u[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa_ / sb_);
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa_ % sb_);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    // Issue one op from the current (post-edge) point; 'poke' re-asserts start with junk
    // operands that many edges after acceptance, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int poke);
        int n;
        n = 0;
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        do begin
            @(posedge clock); #1;
            n++;
            if (n == 1) begin
                start = 1'b0;
                chk({tag, " busy"}, busy, 1'b1);
                op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
            end
            if (poke != 0 && n == poke) begin
                start = 1'b1; funct3 = 3'b101; op_a = 32'd99; op_b = 32'd5;
            end
            if (poke != 0 && n == poke + 1) start = 1'b0;
        end while (!done && n < 60);
        chk({tag, " latency"}, n, exp_lat(f, a, b));
        chk({tag, " result"}, result, exp);
        chk({tag, " rd_out"}, rd_out, rd);
        chk({tag, " writereg"}, writereg_out, rd != 0);
        @(posedge clock); #1;
        chk({tag, " done drop"}, {busy, done, writereg_out}, 3'b000);
        chk({tag, " result hold"}, result, exp);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          sel;

        reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset outs", {busy, done, writereg_out, rd_out}, 8'h00);
        chk("reset result", result, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_op("mul 7x-3",   3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0);
        run_op("mulh",       3'b001, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 0);
        run_op("mulhsu",     3'b010, 32'hFFFF_FFFF,  32'd2,         5'd2,  32'hFFFF_FFFF, 0);
        run_op("mulhu",      3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 0);
        run_op("div -7/2",   3'b100, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 0);
        run_op("rem -7/2",   3'b110, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 0);
        run_op("divu 100/7", 3'b101, 32'd100,        32'd7,         5'd7,  32'd14,        0);
        run_op("remu 100/7", 3'b111, 32'd100,        32'd7,         5'd8,  32'd2,         0);
        run_op("div 5/0",    3'b100, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 0);
        run_op("remu 5/0",   3'b111, 32'd5,          32'd0,         5'd10, 32'd5,         0);
        run_op("div ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
        run_op("rem ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         0);
        run_op("mul ignore", 3'b000, 32'd3,          32'd4,         5'd13, 32'd12,        10);
        run_op("mul rd0",    3'b000, 32'd9,          32'd9,         5'd0,  32'd81,        0);

        // Abort a DIVU mid-flight with an asynchronous reset
        funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd14; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("abort outs", {busy, done, writereg_out, rd_out}, 8'h00);
        chk("abort result", result, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("abort no done", done, 1'b0);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        run_op("mul 6x7", 3'b000, 32'd6, 32'd7, 5'd15, 32'd42, 0);

        for (int i = 0; i < 40; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            rd  = 5'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            run_op($sformatf("rand%0d f%0d", i, f), f, a, b, rd, model(f, a, b), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Iterative RV32M multiply/divide unit that sits between the register file read ports and the register file write port.
- Consumes the two source operand values and the destination register index.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per cycle.
- Returns the result with a one-cycle write strobe that drives the register file write-enable, write data and destination index.
- The control unit stalls the datapath while busy is high.

Parameters:
XLEN, 32, operand/result width in bits; only 32 is supported.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (register file readdata1)
op_b  input  XLEN  rs2 value (register file readdata2)
rd_in  input  5  destination register index
busy  output  1  high from the cycle after start is accepted until the cycle done drops
done  output  1  one-cycle completion pulse
result  output  XLEN  result value; holds until the next done
rd_out  output  5  latched destination index
writereg_out  output  1  register file write strobe: done AND (rd_out != 0)

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, writereg_out, result, rd_out, counter and internal accumulators all go to 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1, at edge E0:
  - Latch funct3 and rd_in.
  - Record the sign of each operand: signed for MULH and DIV/REM; op_a only for MULHSU; none for MULHU/DIVU/REMU/MUL.
  - Latch operand magnitudes; clear the 64-bit accumulator and the 5-bit counter.
  - Go to RUN, busy=1.
- Divide special cases are detected at E0 and skip RUN/FIX; go directly to DONE with result loaded:
  - Divisor = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - In these cases done is high in the cycle after E0.
- RUN: one iteration per edge; counter increments; after 32 iterations (E1..E32) go to FIX.
  - Multiply: shift-add of unsigned magnitudes into the 64-bit product.
  - Divide: restoring division of unsigned magnitudes; quotient and remainder are 32 bits each.
- FIX, at E33:
  - Apply sign correction (two's complement negate).
    - Product: negated when the operand signs differ.
    - Quotient: negated when the signs differ.
    - Remainder: takes the sign of the dividend.
  - Select the output: MUL gives the low 32 bits; MULH/MULHSU/MULHU give the high 32 bits; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register result, go to DONE.
- DONE: done=1 for exactly one cycle; writereg_out=1 unless rd_out=0. Next edge goes to IDLE: busy=0, done=0.
- Latency: normal ops have done high in the cycle after E33, i.e. 34 cycles from the start edge. Special-case divides take 1 cycle.
- start asserted while busy=1 is ignored; operands and rd are not re-latched. Input changes during RUN have no effect.
- start is accepted in the IDLE cycle right after DONE; back-to-back ops are legal.
- rd_in=0: computation runs and done pulses, but writereg_out stays 0.
- Reset mid-operation aborts with no done pulse; the next start after reset behaves normally.
- All arithmetic is modulo 2^32 / 2^64. MULHU 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFE in the high word.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3), rd=5, start at edge E0 -> busy high from E0; result=0xFFFFFFEB, done=1, writereg_out=1 and rd_out=5 in the cycle after E33; busy=0 after E34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each with 34-cycle latency.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done in the cycle after the start edge. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, each 1 cycle.
- Pulse start again at E10 with different operands during a MUL 3x4 -> ignored, result=12. Issue start in the first IDLE cycle after done -> accepted. rd_in=0 -> done pulses, writereg_out stays 0.
- Assert reset at E15 of a DIVU -> all outputs 0 immediately (async), no done pulse. Deassert reset, then MUL 6x7 -> result=42 after 34 cycles.
